result_capture: RTL
===================

Name: result_capture

Overview:
- Capture stage directly downstream of the 8-bit combinational x/y datapath.
- Registers each valid combinational result into a small first-word-fall-through FIFO and presents it to the consumer with a valid/ready handshake.
- The FIFO breaks the timing path from the combinational output to the consumer and absorbs consumer backpressure.
- Also keeps a running count of results accepted since reset.

Parameters:
WIDTH, 8, result word width (matches the combinational datapath width)
DEPTH, 4, FIFO entries; power of two, >= 2
TOTAL_W, 16, width of the accepted-results counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream result on in_data is valid this cycle
in_ready  output  1  stage can accept a word this cycle
in_data  input  WIDTH  result word from the combinational block
out_valid  output  1  out_data holds the oldest stored word
out_ready  input  1  consumer takes out_data this cycle
out_data  output  WIDTH  oldest stored word; 0 when empty
level  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH
total  output  TOTAL_W  count of accepted pushes since reset; wraps modulo 2^TOTAL_W

Behaviour:
- Reset: one clock and one reset (clk, rst); reset is synchronous and active-high.
- While rst is high at a clock edge:
  - wr_ptr, rd_ptr, level and total all clear to 0.
  - After the edge: out_valid=0, out_data=0, in_ready=1.
  - Storage contents are not reset.
  - rst overrides any push or pop in the same cycle; a mid-stream reset discards all stored words.
- push = in_valid & in_ready
- pop = out_valid & out_ready
- in_ready = (level != DEPTH):
  - Driven from registered state only; no combinational path from out_ready or in_valid.
  - When full, push is refused even if a pop occurs in the same cycle.
- out_valid = (level != 0):
  - out_data = mem[rd_ptr] when out_valid, else 0.
  - Read side is first-word fall-through.
- Latency:
  - A word pushed at edge N appears on out_data/out_valid after edge N, i.e. in cycle N+1, if the FIFO was empty.
  - There is no same-cycle bypass from in_data to out_data.
- On each edge with push, mem[wr_ptr] <= in_data and wr_ptr advances by 1, wrapping DEPTH-1 -> 0.
- On each edge with pop, rd_ptr advances by 1 with the same wrap.
- Level update per edge:
  - push only: level +1
  - pop only: level -1
  - push and pop together: level unchanged
  - neither: unchanged
- total increments by 1 on every push, independent of pop, and wraps to 0 after 2^TOTAL_W-1.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Simultaneous push and pop while empty cannot occur, because pop requires out_valid.
- Assertions:
  - Never push when level==DEPTH.
  - Never pop when level==0.
  - level equals (wr_ptr - rd_ptr) mod DEPTH, except when full, where wr_ptr==rd_ptr and level==DEPTH.

Decomposition:
- Shared package timing_tut_pkg holds:
  - Parameter WORD_W=8
  - Typedef word_t (logic [WORD_W-1:0]), used for in_data/out_data and for the combinational block's x/y/out.
- No sub-module: pointers, level, storage array and counter all stay in result_capture.

Test Plan:
- Reset then idle: hold rst high for 2 cycles, then release -> out_valid=0, out_data=0, in_ready=1, level=0, total=0.
- Single word: push 0x5A with out_ready=0 -> next cycle out_valid=1, out_data=0x5A, level=1, total=1. Assert out_ready for one cycle -> out_valid=0, level=0.
- Fill and backpressure:
  - With out_ready=0, push 0x01,0x02,0x03,0x04 -> level=4, in_ready=0.
  - Assert in_valid with 0x05 -> not accepted; total stays 4.
  - Drain -> outputs 0x01..0x04 in order.
- Full with simultaneous events: at level=4, assert out_ready=1 and in_valid=1 with 0x05 -> 0x01 popped, 0x05 refused that cycle, level=3. Next cycle 0x05 is accepted.
- Streaming and wrap-around: push 0x10..0x19 back-to-back with out_ready=1 -> level stays at most 1 and every word appears exactly once in order. Pointers wrap twice with no loss; total=10.
- Reset mid-operation: with level=3, pulse rst for 1 cycle -> level=0, out_valid=0, total=0. The next push of 0xA5 is the first word out.

Source files
------------

// File: rtl/timing_tut_pkg.sv
// Shared types for the tutorial x/y datapath and its capture stage.
package timing_tut_pkg;

  localparam int unsigned WORD_W = 8;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/result_capture.sv
// Capture stage: FWFT FIFO between the combinational x/y datapath and its consumer,
// plus a running count of accepted results.
module result_capture
  import timing_tut_pkg::*;
#(
  parameter int unsigned WIDTH   = WORD_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TOTAL_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [TOTAL_W-1:0]         total
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               push_c, pop_c;

  // Handshake status decodes registered state only, so in_ready never sees out_ready.
  assign in_ready  = (level_q != LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign total     = total_q;

  assign push_c = in_valid & in_ready;
  assign pop_c  = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    total_d  = total_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      total_d         = total_q + TOTAL_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage is deliberately left out of reset; out_data is masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      total_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      total_q  <= total_d;
    end
  end

  a_no_push_full : assert property (@(posedge clk) disable iff (rst)
    !(push_c && level_q == LVL_W'(DEPTH)));

  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
    !(pop_c && level_q == '0));

  // Full and empty both have equal pointers; the level's low bits disambiguate nothing else.
  a_level_ptrs : assert property (@(posedge clk) disable iff (rst)
    (PTR_W'(wr_ptr_q - rd_ptr_q) == level_q[PTR_W-1:0]) && (level_q <= LVL_W'(DEPTH)));

endmodule
